// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a word-wide data memory; sub-word stores use read-modify-write.
// Latency: error 1, SW 2, load 3, SB/SH 4 cycles to resp_valid. Holds req_ready low from accept until the response has gone out.
module load_store_unit #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_RD   = 3'd1;
    localparam logic [2:0] LD_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] RMW_RD  = 3'd4;
    localparam logic [2:0] RMW_MRG = 3'd5;
    localparam logic [2:0] RESP    = 3'd6;

    localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) * 33'd4;

    logic [2:0]  state;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [4:0]  lat_rd;
    logic        lat_err;
    logic [31:0] data;
    logic        req_legal;
    logic        req_err;

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        if (f3[1:0] == 2'b00)
            m[{lo, 3'b000} +: 8] = wd[7:0];
        else
            m[{lo[1], 4'b0000} +: 16] = wd[15:0];
        store_merge = m;
    endfunction

    // Illegal encodings, misalignment and out-of-range addresses all collapse into one error.
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = !req_addr[0];
            3'b010:  req_legal = (req_addr[1:0] == 2'b00);
            3'b100:  req_legal = !req_is_store;
            3'b101:  req_legal = !req_is_store && !req_addr[0];
            default: req_legal = 1'b0;
        endcase
        req_err = !req_legal || ({1'b0, req_addr} >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_rd     <= 5'd0;
            lat_err    <= 1'b0;
            data       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_store  <= req_is_store;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_rd     <= req_rd;
                        lat_err    <= req_err;
                        data       <= req_err ? 32'd0 : req_wdata;
                        if (req_err)
                            state <= RESP;
                        else if (!req_is_store)
                            state <= LD_RD;
                        else if (req_funct3 == 3'b010)
                            state <= ST_WR;
                        else
                            state <= RMW_RD;
                    end
                end
                LD_RD:   state <= LD_CAP;
                LD_CAP: begin
                    data  <= load_extract(lat_funct3, lat_addr[1:0], mem_read_data);
                    state <= RESP;
                end
                RMW_RD:  state <= RMW_MRG;
                RMW_MRG: begin
                    data  <= store_merge(lat_funct3, lat_addr[1:0], mem_read_data, lat_wdata);
                    state <= ST_WR;
                end
                ST_WR:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // rst_n gates req_ready directly so it is low for the whole reset, not just after the first edge.
    always_comb begin
        req_ready       = rst_n && (state == IDLE);
        mem_read_en     = (state == LD_RD) || (state == RMW_RD);
        mem_write_en    = (state == ST_WR);
        mem_addr        = (mem_read_en || mem_write_en) ? {lat_addr[31:2], 2'b00} : 32'd0;
        mem_write_data  = mem_write_en ? data : 32'd0;
        mem_byte_enable = mem_write_en ? 4'b1111 : 4'b0000;
        resp_valid      = (state == RESP);
        resp_data       = (resp_valid && !lat_store && !lat_err) ? data : 32'd0;
        resp_rd         = resp_valid ? lat_rd : 5'd0;
        resp_err        = resp_valid && lat_err;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory behind the DUT, arithmetic model of each request, per-cycle compare.
module tb_load_store_unit;

    localparam int DW = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_read_data;

    load_store_unit #(.DMEM_WORDS(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_byte_enable(mem_byte_enable), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1 || i == 2) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0003;
    endfunction

    // Data memory seen by the DUT: read data appears only in the cycle after mem_read_en.
    logic [31:0] dmem [DW];
    bit          dmem_init = 0;
    always @(posedge clk) begin
        if (!dmem_init) begin
            for (int i = 0; i < DW; i++) dmem[i] = init_word(i);
            dmem_init = 1;
        end
        if (mem_read_en)
            mem_read_data <= (mem_addr[31:2] < DW) ? dmem[mem_addr[31:2]] : 32'd0;
        else
            mem_read_data <= 32'hA5A5_A5A5;
        if (mem_write_en && mem_addr[31:2] < DW)
            dmem[mem_addr[31:2]] = mem_write_data;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] model_mem [DW];
    int          acc = -1, exp_read_cyc = -1, exp_write_cyc = -1, exp_resp_cyc = -1;
    logic [31:0] exp_maddr, exp_wdata, exp_data;
    logic [4:0]  exp_rd;
    logic        exp_err;
    int          obs_read_cyc, obs_write_cyc, obs_resp_cyc;
    logic [31:0] obs_wdata, obs_waddr, obs_data;
    logic [3:0]  obs_be;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle_check();
        bit busy, rexp, wexp, vexp;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_mem_en", {30'd0, mem_read_en, mem_write_en}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
        end else begin
            busy = (cyc > acc) && (cyc <= exp_resp_cyc);
            rexp = (cyc == exp_read_cyc);
            wexp = (cyc == exp_write_cyc);
            vexp = (cyc == exp_resp_cyc);
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("mem_read_en", 32'(mem_read_en), 32'(rexp));
            chk("mem_write_en", 32'(mem_write_en), 32'(wexp));
            chk("mem_addr", mem_addr, (rexp || wexp) ? exp_maddr : 32'd0);
            chk("mem_byte_enable", 32'(mem_byte_enable), wexp ? 32'hF : 32'h0);
            if (wexp) begin
                chk("mem_write_data", mem_write_data, exp_wdata);
                model_mem[exp_maddr[31:2]] = exp_wdata;
            end
            if (mem_read_en) obs_read_cyc = cyc;
            if (mem_write_en) begin
                obs_write_cyc = cyc;
                obs_wdata = mem_write_data;
                obs_waddr = mem_addr;
                obs_be = mem_byte_enable;
            end
            chk("resp_valid", 32'(resp_valid), 32'(vexp));
            chk("resp_data", resp_data, vexp ? exp_data : 32'd0);
            chk("resp_rd", 32'(resp_rd), vexp ? 32'(exp_rd) : 32'd0);
            chk("resp_err", 32'(resp_err), vexp ? 32'(exp_err) : 32'd0);
            if (resp_valid) begin
                obs_resp_cyc = cyc;
                obs_data = resp_data;
                obs_err = resp_err;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        cycle_check();
    endtask

    // Model a request from the architectural rules, then drive it and (optionally) follow it to its response.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit wait_done);
        int n, sz, lo, lat;
        bit bad;
        logic [31:0] word, sh, v, mask;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (n == 20) chk("ready_timeout", 32'(req_ready), 1);
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lo  = int'(a[1:0]);
        bad = !((f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5)));
        bad = bad || ((a & 32'(sz - 1)) != 0) || (64'(a) >= 64'(DW * 4));
        word = bad ? 32'd0 : model_mem[a[31:2]];
        sh = word >> (8 * lo);
        if (sz == 1) begin
            v = sh & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = sh & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
        end else v = sh;
        mask = ((sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF) << (8 * lo);
        lat = bad ? 1 : !st ? 3 : (sz == 4) ? 2 : 4;
        acc = cyc;
        exp_read_cyc  = (!bad && (!st || sz < 4)) ? acc + 1 : -1;
        exp_write_cyc = (!bad && st) ? ((sz == 4) ? acc + 1 : acc + 3) : -1;
        exp_resp_cyc  = acc + lat;
        exp_maddr = {a[31:2], 2'b00};
        exp_wdata = (word & ~mask) | ((wd << (8 * lo)) & mask);
        exp_data  = (!bad && !st) ? v : 32'd0;
        exp_rd    = rd;
        exp_err   = bad;
        obs_read_cyc = -1; obs_write_cyc = -1; obs_resp_cyc = -1;
        obs_wdata = 0; obs_waddr = 0; obs_be = 0; obs_data = 32'hFFFF_FFFF; obs_err = 1'bx;
        req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1;
        // Keep junk on the request bus while busy; it must be ignored.
        req_valid    = wait_done;
        req_is_store = 1'($urandom);
        req_funct3   = 3'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_rd       = 5'($urandom);
        if (wait_done) begin
            n = 0;
            while (n < 20) begin
                tick();
                n++;
                if (cyc >= exp_resp_cyc) break;
            end
            req_valid = 0;
            if (n == 20) chk("resp_timeout", 32'(cyc), 32'(exp_resp_cyc));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DW; i++) model_mem[i] = init_word(i);
        rst_n = 0; req_valid = 0; req_is_store = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0;
        #1;
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_outputs", {mem_addr[15:0], 12'd0, mem_read_en, mem_write_en, resp_valid, resp_err}, 0);
        tick(); tick();
        #2 rst_n = 1;
        #1 chk("ready_after_release", 32'(req_ready), 1);

        issue(0, 3'b000, 32'h4, 0, 5'd3, 1);
        chk("lb_model_pin", exp_data, 32'hFFFF_FFEF);
        chk("lb_data", obs_data, 32'hFFFF_FFEF);
        chk("lb_read_lat", 32'(obs_read_cyc - acc), 1);
        chk("lb_resp_lat", 32'(obs_resp_cyc - acc), 3);

        issue(0, 3'b101, 32'h6, 0, 5'd4, 1);
        chk("lhu_data", obs_data, 32'h0000_DEAD);
        chk("lhu_err", 32'(obs_err), 0);

        issue(1, 3'b000, 32'h9, 32'h12, 5'd5, 1);
        chk("sb_wdata", obs_wdata, 32'hDEAD_12EF);
        chk("sb_waddr", obs_waddr, 32'h8);
        chk("sb_be", 32'(obs_be), 32'hF);
        chk("sb_read_lat", 32'(obs_read_cyc - acc), 1);
        chk("sb_write_lat", 32'(obs_write_cyc - acc), 3);
        chk("sb_resp_lat", 32'(obs_resp_cyc - acc), 4);

        issue(0, 3'b010, 32'h2, 0, 5'd6, 1);
        chk("lw_mis_err", 32'(obs_err), 1);
        chk("lw_mis_data", obs_data, 0);
        chk("lw_mis_lat", 32'(obs_resp_cyc - acc), 1);
        chk("lw_mis_noread", 32'(obs_read_cyc), 32'hFFFF_FFFF);

        issue(1, 3'b010, 32'h400, 32'h55, 5'd7, 1);
        chk("sw_oor_err", 32'(obs_err), 1);
        chk("sw_oor_lat", 32'(obs_resp_cyc - acc), 1);
        chk("sw_oor_nowrite", 32'(obs_write_cyc), 32'hFFFF_FFFF);

        issue(0, 3'b001, 32'h6, 0, 5'd8, 1);
        chk("lh_data", obs_data, 32'hFFFF_DEAD);
        issue(0, 3'b100, 32'h7, 0, 5'd9, 1);
        chk("lbu_data", obs_data, 32'h0000_00DE);
        issue(1, 3'b010, 32'h10, 32'h8765_4321, 5'd10, 1);
        chk("sw_resp_lat", 32'(obs_resp_cyc - acc), 2);
        issue(1, 3'b001, 32'h12, 32'hAAAA_CAFE, 5'd11, 1);
        chk("sh_wdata", obs_wdata, 32'hCAFE_4321);
        issue(0, 3'b010, 32'h10, 0, 5'd12, 1);
        chk("lw_after_sh", obs_data, 32'hCAFE_4321);
        issue(0, 3'b011, 32'h0, 0, 5'd13, 1);
        issue(1, 3'b100, 32'h4, 32'h1, 5'd14, 1);
        issue(0, 3'b001, 32'h5, 0, 5'd15, 1);
        issue(0, 3'b010, 32'h3FC, 0, 5'd16, 1);
        issue(0, 3'b000, 32'h3FF, 0, 5'd17, 1);
        issue(0, 3'b000, 32'h400, 0, 5'd18, 1);
        chk("lb_oor_err", 32'(obs_err), 1);

        // Reset while the SH is merging: the write must never happen.
        issue(1, 3'b001, 32'hA, 32'h0000_BEEF, 5'd19, 0);
        tick(); tick();
        #2 rst_n = 0;
        acc = -1; exp_read_cyc = -1; exp_write_cyc = -1; exp_resp_cyc = -1;
        #1;
        chk("abort_outputs", {mem_addr[27:0], mem_read_en, mem_write_en, resp_valid, req_ready}, 0);
        tick(); tick();
        #2 rst_n = 1;
        #1 chk("abort_ready", 32'(req_ready), 1);
        repeat (5) tick();
        chk("abort_nowrite", 32'(obs_write_cyc), 32'hFFFF_FFFF);
        issue(0, 3'b010, 32'h8, 0, 5'd20, 1);
        chk("abort_word_intact", obs_data, 32'hDEAD_12EF);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 256, number of 32-bit words in data memory.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: req_valid input 1, req_ready output 1  pipeline request handshake.
REQ-005 SHALL have: req_is_store input 1; req_funct3 input 3; req_addr input 32 byte address; req_wdata input 32; req_rd input 5 destination tag.
REQ-006 SHALL have: resp_valid output 1 one-cycle pulse; resp_data output 32; resp_rd output 5; resp_err output 1.
REQ-007 SHALL have: mem_addr output 32; mem_write_data output 32; mem_write_en output 1; mem_read_en output 1; mem_byte_enable output 4; mem_read_data input 32.

Function
REQ-008 SHALL use states IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RESP.
REQ-009 SHALL assert req_ready iff state is IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, latching all req_* fields.
REQ-010 SHALL decode funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU (loads only); any other code, or 100/101 with req_is_store=1, is illegal.
REQ-011 SHALL flag an error if illegal, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= DMEM_WORDS*4.
REQ-012 On an error request, SHALL go IDLE->RESP with no memory access; resp_err=1, resp_data=0.
REQ-013 Load: IDLE->LD_RD (mem_read_en=1)->LD_CAP (register mem_read_data)->RESP; accept at cycle T gives resp_valid at T+3.
REQ-014 Memory read data is valid only in the cycle after mem_read_en; SHALL capture it in exactly that cycle.
REQ-015 Load extraction: byte lane k=addr[1:0] is bits [8k+7:8k]; halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-016 SW: IDLE->ST_WR (mem_write_en=1, data=req_wdata)->RESP; resp_valid at T+2.
REQ-017 SB/SH: data memory commits only full-word writes, so SHALL read-modify-write: IDLE->RMW_RD (read)->RMW_MRG (replace addressed lane(s) with wdata[7:0]/[15:0])->ST_WR (write merged word)->RESP; resp_valid at T+4.
REQ-018 mem_addr SHALL be {addr[31:2],2'b00} of the latched request whenever read or write enable is high; 0 otherwise.
REQ-019 mem_byte_enable SHALL be 4'b1111 whenever mem_write_en=1; 0 otherwise.
REQ-020 mem_read_en and mem_write_en SHALL never be high in the same cycle; each is high for exactly one cycle per access.
REQ-021 In RESP, SHALL drive resp_valid=1 for one cycle with resp_rd=latched rd; stores return resp_data=0, resp_err=0; next state IDLE.
REQ-022 resp_data, resp_rd and resp_err SHALL be 0 whenever resp_valid=0.
REQ-023 req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and drive all outputs to 0, including req_ready (0 while in reset).
REQ-025 Reset mid-operation SHALL abort the access: no write issued afterward, no resp_valid for the aborted request.
REQ-026 First rising edge after rst_n rises SHALL see req_ready=1.

Verification
REQ-027 Memory word 1 = 0xDEADBEEF; LB addr 0x4 at T -> mem_read_en at T+1, resp_valid at T+3, resp_data 0xFFFFFFEF.
REQ-028 LHU addr 0x6 on 0xDEADBEEF -> resp_data 0x0000DEAD, resp_err=0.
REQ-029 SB wdata 0x12 addr 0x9, word 2 = 0xDEADBEEF -> read at T+1, write 0xDEAD12EF, byte_enable 1111, addr 0x8 at T+3, resp_valid at T+4.
REQ-030 LW addr 0x2 -> no mem enables, resp_valid at T+1, resp_err=1, resp_data 0; SW addr 0x400 (DMEM_WORDS=256) -> same.
REQ-031 rst_n low during RMW_MRG of an SH -> outputs 0 immediately, mem_write_en never pulses, no resp_valid; req_ready=1 after release.
